// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding and status widths.
// The DE5 top level imports the same package to decode sequencer status.
package reset_sequencer_pkg;

    localparam int unsigned STATE_W   = 2;
    localparam int unsigned RESTART_W = 8;

    localparam logic [STATE_W-1:0] ST_HOLD      = 2'd0;
    localparam logic [STATE_W-1:0] ST_WAIT_LOCK = 2'd1;
    localparam logic [STATE_W-1:0] ST_RELEASE   = 2'd2;
    localparam logic [STATE_W-1:0] ST_RUN       = 2'd3;

endpackage

// File: rtl/reset_sequencer_sat_counter.sv
// Saturating up-counter with synchronous clear; used for the restart counter.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk_50mhz,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk_50mhz) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != {W{1'b1}})) begin
            count <= count + W'(1);
        end
    end

endmodule

// File: rtl/reset_sequencer.sv
// Multi-domain reset sequencer: hold, wait for masked PLL lock, then staggered
// release in ascending domain order; re-runs on soft reset or masked lock loss.
module reset_sequencer
    import reset_sequencer_pkg::*;
#(
    parameter int unsigned                 NUM_DOMAINS    = 4,
    parameter int unsigned                 HOLD_CYCLES    = 1024,
    parameter int unsigned                 STAGGER_CYCLES = 64,
    parameter logic [NUM_DOMAINS-1:0]      LOCK_MASK      = NUM_DOMAINS'(4'b0011),
    parameter int unsigned                 LOCK_TIMEOUT   = 65536,
    parameter int unsigned                 CNT_W          = 20
) (
    input  logic                   clk_50mhz,
    input  logic                   rst_50mhz_n,
    input  logic                   soft_reset_in,
    input  logic [NUM_DOMAINS-1:0] pll_locked,
    output logic [NUM_DOMAINS-1:0] domain_reset_out,
    output logic                   all_released,
    output logic                   busy,
    output logic                   lock_timeout,
    output logic [RESTART_W-1:0]   restart_count
);

    localparam longint unsigned CNT_MAX  = (64'd1 << CNT_W) - 64'd1;
    localparam longint unsigned REL_SPAN = 64'(STAGGER_CYCLES) * 64'(NUM_DOMAINS - 1);

    if (NUM_DOMAINS > 16 || NUM_DOMAINS < 1) begin : g_chk_domains
        $fatal(1, "reset_sequencer: NUM_DOMAINS must be 1..16");
    end
    if (64'(HOLD_CYCLES) > CNT_MAX || 64'(LOCK_TIMEOUT) > CNT_MAX ||
        64'(STAGGER_CYCLES) > CNT_MAX || REL_SPAN > CNT_MAX) begin : g_chk_width
        $fatal(1, "reset_sequencer: cycle parameter exceeds CNT_W range");
    end

    localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] REL_LAST     = CNT_W'(REL_SPAN);

    logic [STATE_W-1:0]     state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic [NUM_DOMAINS-1:0] dom_rst_d;
    logic                   restart_inc_c;
    logic                   timeout_set_c;
    logic                   lock_ok_c;

    assign lock_ok_c = ((pll_locked & LOCK_MASK) == LOCK_MASK);

    // Next-state, counter and per-domain release decisions
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        dom_rst_d     = domain_reset_out;
        restart_inc_c = 1'b0;
        timeout_set_c = 1'b0;

        case (state_q)
            ST_HOLD: begin
                dom_rst_d = '1;
                if (soft_reset_in) begin
                    cnt_d = '0;
                end else if (cnt_q == HOLD_LAST) begin
                    state_d = ST_WAIT_LOCK;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_WAIT_LOCK: begin
                dom_rst_d = '1;
                if (soft_reset_in) begin
                    state_d       = ST_HOLD;
                    cnt_d         = '0;
                    restart_inc_c = 1'b1;
                end else if (lock_ok_c) begin
                    state_d = ST_RELEASE;
                    cnt_d   = '0;
                end else if (cnt_q == TIMEOUT_LAST) begin
                    state_d       = ST_HOLD;
                    cnt_d         = '0;
                    restart_inc_c = 1'b1;
                    timeout_set_c = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RELEASE: begin
                if (soft_reset_in || !lock_ok_c) begin
                    state_d       = ST_HOLD;
                    cnt_d         = '0;
                    dom_rst_d     = '1;
                    restart_inc_c = 1'b1;
                end else begin
                    for (int i = 0; i < int'(NUM_DOMAINS); i++) begin
                        if (cnt_q == CNT_W'(64'(i) * 64'(STAGGER_CYCLES))) begin
                            dom_rst_d[i] = 1'b0;
                        end
                    end
                    if (cnt_q == REL_LAST) begin
                        state_d = ST_RUN;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
            end
            ST_RUN: begin
                dom_rst_d = '0;
                if (soft_reset_in || !lock_ok_c) begin
                    state_d       = ST_HOLD;
                    cnt_d         = '0;
                    dom_rst_d     = '1;
                    restart_inc_c = 1'b1;
                end
            end
            default: begin
                state_d   = ST_HOLD;
                cnt_d     = '0;
                dom_rst_d = '1;
            end
        endcase
    end

    // State, counter and registered status outputs
    always_ff @(posedge clk_50mhz) begin
        if (!rst_50mhz_n) begin
            state_q          <= ST_HOLD;
            cnt_q            <= '0;
            domain_reset_out <= '1;
            busy             <= 1'b1;
            all_released     <= 1'b0;
            lock_timeout     <= 1'b0;
        end else begin
            state_q          <= state_d;
            cnt_q            <= cnt_d;
            domain_reset_out <= dom_rst_d;
            busy             <= (state_d != ST_RUN);
            all_released     <= (state_d == ST_RUN);
            lock_timeout     <= lock_timeout | timeout_set_c;
        end
    end

    sat_counter #(
        .W(RESTART_W)
    ) u_restart_cnt (
        .clk_50mhz (clk_50mhz),
        .clr       (!rst_50mhz_n),
        .inc       (restart_inc_c),
        .count     (restart_count)
    );

endmodule
